// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: instruction field positions,
// the default reset PC and the fetch FSM state type.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNC_MSB   = 5;
  localparam int FUNC_LSB   = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FULL
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Resolves control-flow redirects from execute into a single target address.
// Priority is JR over J over taken branch; ADDR_W must be at least 29.
module next_pc_calc
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              ex_jump,
  input  logic              ex_jump_register,
  input  logic              ex_branch,
  input  logic              ex_branch_taken,
  input  logic [ADDR_W-1:0] ex_pc_plus4,
  input  logic [25:0]       ex_instr_index,
  input  logic [15:0]       ex_imm,
  input  logic [31:0]       ex_rs_value,
  output logic              redirect,
  output logic [ADDR_W-1:0] target,
  output logic              misalign
);

  logic [ADDR_W-1:0] jr_target;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] br_target;

  assign jr_target = ADDR_W'({ex_rs_value[31:2], 2'b00});
  assign j_target  = {ex_pc_plus4[ADDR_W-1:28], ex_instr_index, 2'b00};
  // Branch offset is sign-extended; the add wraps at the address width.
  assign br_target = ex_pc_plus4 + ADDR_W'($signed({ex_imm, 2'b00}));

  assign redirect = ex_jump_register | ex_jump | (ex_branch & ex_branch_taken);
  assign misalign = ex_jump_register & (ex_rs_value[1:0] != 2'b00);

  always_comb begin
    // NOTE: default assignment first so no path leaves target unassigned (no latch).
    target = br_target;
    if (ex_jump)          target = j_target;
    if (ex_jump_register) target = jr_target;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding request to a
// variable-latency instruction memory and holds the fetched word for decode.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [5:0]        out_opcode,
  output logic [5:0]        out_func,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_plus4,
  input  logic              ex_jump,
  input  logic              ex_jump_register,
  input  logic              ex_branch,
  input  logic              ex_branch_taken,
  input  logic [ADDR_W-1:0] ex_pc_plus4,
  input  logic [25:0]       ex_instr_index,
  input  logic [15:0]       ex_imm,
  input  logic [31:0]       ex_rs_value,
  output logic              misalign_err
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic              kill_q;
  logic              out_valid_q;
  logic [31:0]       out_instr_q;
  logic [ADDR_W-1:0] out_pc_q;
  logic [ADDR_W-1:0] out_pc_plus4_q;
  logic              misalign_q;

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              misalign;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc_calc (
    .ex_jump          (ex_jump),
    .ex_jump_register (ex_jump_register),
    .ex_branch        (ex_branch),
    .ex_branch_taken  (ex_branch_taken),
    .ex_pc_plus4      (ex_pc_plus4),
    .ex_instr_index   (ex_instr_index),
    .ex_imm           (ex_imm),
    .ex_rs_value      (ex_rs_value),
    .redirect         (redirect),
    .target           (target),
    .misalign         (misalign)
  );

  assign pc_inc = pc_q + ADDR_W'(4);

  // A redirect in the request cycle suppresses the strobe so no wrong-path fetch leaves.
  assign imem_req     = (state_q == S_REQ) & ~redirect;
  assign imem_addr    = pc_q;
  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_opcode   = out_instr_q[OPCODE_MSB:OPCODE_LSB];
  assign out_func     = out_instr_q[FUNC_MSB:FUNC_LSB];
  assign out_pc       = out_pc_q;
  assign out_pc_plus4 = out_pc_plus4_q;
  assign misalign_err = misalign_q;

  // NOTE: state uses non-blocking assignments and a synchronous reset sampled on clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      kill_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      out_instr_q    <= '0;
      out_pc_q       <= '0;
      out_pc_plus4_q <= '0;
      misalign_q     <= 1'b0;
    end else begin
      misalign_q <= misalign;
      unique case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (redirect) pc_q    <= target;
          else          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_valid) begin
            if (kill_q | redirect) begin
              // Wrong-path response: drop it and refetch from the current PC.
              kill_q  <= 1'b0;
              state_q <= S_REQ;
              if (redirect) pc_q <= target;
            end else begin
              out_instr_q    <= imem_rdata;
              out_pc_q       <= pc_q;
              out_pc_plus4_q <= pc_inc;
              pc_q           <= pc_inc;
              out_valid_q    <= 1'b1;
              state_q        <= S_FULL;
            end
          end else if (redirect) begin
            pc_q   <= target;
            kill_q <= 1'b1;
          end
        end
        S_FULL: begin
          if (redirect) begin
            pc_q        <= target;
            out_valid_q <= 1'b0;
            state_q     <= S_REQ;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of the opcode/func decoder (controller) and supplies it the fetched instruction word.
- Holds the architectural PC and issues one-outstanding requests to a variable-latency instruction memory.
- Presents a registered instruction to decode over a valid/ready handshake.
- Consumes the decoder's jump, branch and jump_register outputs, resolved in execute, to redirect the PC and kill wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- ADDR_W, 32, width of PC and memory address.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  one-cycle request strobe to instruction memory.
- imem_addr  out  ADDR_W  request address (current PC).
- imem_rdata  in  32  returned instruction word.
- imem_valid  in  1  rdata valid; arrives >=1 cycle after imem_req.
- out_valid  out  1  instruction held for decode.
- out_ready  in  1  decode accepts the held instruction.
- out_instr  out  32  held instruction.
- out_opcode  out  6  out_instr[31:26], combinational slice.
- out_func  out  6  out_instr[5:0], combinational slice.
- out_pc  out  ADDR_W  address of the held instruction.
- out_pc_plus4  out  ADDR_W  out_pc+4.
- ex_jump  in  1  J/JAL resolved.
- ex_jump_register  in  1  JR resolved.
- ex_branch  in  1  branch instruction in execute.
- ex_branch_taken  in  1  branch condition true.
- ex_pc_plus4  in  ADDR_W  pc_plus4 of the resolving instruction.
- ex_instr_index  in  26  J-type target field.
- ex_imm  in  16  branch offset.
- ex_rs_value  in  32  JR target register value.
- misalign_err  out  1  one-cycle pulse: JR target low bits nonzero.

Behaviour:
- Reset values: pc=RESET_PC, state=S_IDLE, kill=0, imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_pc_plus4=0, misalign_err=0.
- redirect = ex_jump_register | ex_jump | (ex_branch & ex_branch_taken).
- Target priority is jump_register > jump > branch:
  - JR target: {ex_rs_value[31:2],2'b00}. misalign_err=1 the cycle after a JR redirect with ex_rs_value[1:0]!=0.
  - J target: {ex_pc_plus4[31:28], ex_instr_index, 2'b00}.
  - Branch target: ex_pc_plus4 + sign-extended {ex_imm,2'b00}, computed mod 2^32 (wraps, no error).
- pc+4 wraps mod 2^32: 32'hFFFF_FFFC -> 32'h0.
- FSM:
  - S_IDLE: one cycle after reset, then S_REQ.
  - S_REQ: imem_req = !redirect (combinational gate), imem_addr=pc.
    - No redirect: go S_WAIT.
    - Redirect: pc<=target, stay S_REQ, no request issued.
  - S_WAIT: imem_req=0.
    - imem_valid & !kill & !redirect: out_instr<=rdata, out_pc<=pc, out_pc_plus4<=pc+4, pc<=pc+4, out_valid<=1, go S_FULL.
    - imem_valid & (kill|redirect): discard response, kill<=0, go S_REQ; on redirect also pc<=target.
    - Redirect without imem_valid: pc<=target, kill<=1, stay S_WAIT.
  - S_FULL: out_valid=1, outputs stable.
    - redirect: pc<=target, out_valid<=0, go S_REQ. This applies even if out_ready is high the same cycle.
    - out_ready without redirect: out_valid<=0, go S_REQ.
- Minimum fetch throughput: 1 instruction per 3 cycles at memory latency 1.
- imem_valid outside S_WAIT is ignored.
- Reset mid-operation: reset dominates every input. The memory is reset on the same reset, so no stale response survives.
- out_* change only on capture into S_FULL.

Decomposition:
- Shared package mips_pkg: opcode/func field position constants, RESET_PC default, FSM state typedef (S_IDLE, S_REQ, S_WAIT, S_FULL).
- Sub-module next_pc_calc (combinational): produces redirect, target, misalign from the ex_* inputs.

Test Plan:
- Reset, memory latency 1, rdata sequence 0x20080005, 0x00000000; out_ready=1 -> imem_addr 0x0 then 0x4; out_instr 0x20080005 with out_opcode 6'b001000, out_pc 0x0, out_pc_plus4 0x4.
- out_ready=0 for 5 cycles while S_FULL -> out_valid held, out_instr stable, no imem_req; ready=1 -> next imem_addr 0x4.
- Latency 3; ex_jump, ex_pc_plus4=0x1000_0010, index=0x000_0040 during S_WAIT -> response discarded (no out_valid), next imem_addr 0x1000_0100.
- Branch: ex_pc_plus4=0x20, imm=16'hFFFE, taken -> next addr 0x18; same with taken=0 -> sequential.
- JR with ex_rs_value=0x0000_0103 -> imem_addr 0x100, misalign_err pulses one cycle; simultaneous JR+J -> JR target used.
- pc=0xFFFF_FFFC fetch -> next imem_addr 0x0; reset asserted in S_WAIT -> next cycle all outputs at reset values, first request at RESET_PC.
